seq_mult_sxu: RTL and testbench

Multi-cycle signed-by-unsigned multiply-accumulate unit for the CNN datapath. It is the parametrised, sequential successor of the 2-bit sign-extended multiplier cell. Operand a is signed and is formed as {as, a}. Operand b is unsigned. The block computes the exact product over WB cycles, one b bit per cycle, and can either start a new running sum or add into it. Valid/ready handshakes sit on both sides so the block drops into the streaming weight/activation pipeline.

---
 rtl/seq_mult_sxu_pkg.sv | 26 ++
 rtl/seq_mult_sxu_acc_add_ovf.sv | 16 +
 rtl/seq_mult_sxu.sv | 111 +++++++++++
 tb/tb_seq_mult_sxu.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_sxu_pkg.sv
// Shared types and width helpers for the sequential signed-by-unsigned MAC.
// The widths depend on the instance parameters, so they are provided as constant functions.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ACC,
    DONE
  } state_t;

  // Width of the exact product of a (wa+1)-bit signed and a wb-bit unsigned operand.
  function automatic int prod_width(input int wa, input int wb);
    return wa + wb + 1;
  endfunction

  // Width of the counter that walks the bits of b.
  function automatic int cnt_width(input int wb);
    return $clog2(wb + 1);
  endfunction

  function automatic bit acc_width_ok(input int acc_w, input int pw);
    return acc_w >= pw;
  endfunction

endpackage

// File: rtl/seq_mult_sxu_acc_add_ovf.sv
// Combinational signed adder for the running sum.
// ovf flags a two's-complement overflow of the W-bit result.
module acc_add_ovf #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  assign sum = a + b;
  // Overflow only when both addends share a sign and the result's sign differs.
  assign ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/seq_mult_sxu.sv
// Multi-cycle signed {as,a} x unsigned b multiply-accumulate, one b bit per cycle.
// Valid/ready handshake on both sides; acc/ovf persist until a load transaction or reset.
module seq_mult_sxu
  import mult_pkg::*;
#(
  parameter int WA    = 2,
  parameter int WB    = 2,
  parameter int ACC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 as,
  input  logic [WA-1:0]        a,
  input  logic [WB-1:0]        b,
  input  logic                 acc_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WA+WB:0]       mul,
  output logic [ACC_W-1:0]     acc,
  output logic                 ovf
);

  localparam int PW = prod_width(WA, WB);
  localparam int CW = cnt_width(WB);

  if (!acc_width_ok(ACC_W, PW)) begin : g_bad_acc_w
    $error("seq_mult_sxu: ACC_W must be at least WA+WB+1");
  end

  state_t                 state, state_nx;
  logic signed [PW-1:0]   mcand;    // sext({as,a}) pre-shifted to the current bit weight
  logic signed [PW-1:0]   prod;
  logic [WB-1:0]          op_b;     // shifts right so bit 0 is always the current b bit
  logic                   mode;
  logic [CW-1:0]          cnt;
  logic                   last_bit;
  logic [ACC_W-1:0]       prod_ext;
  logic [ACC_W-1:0]       acc_sum;
  logic                   add_ovf;

  assign last_bit = (cnt == CW'(WB - 1));
  assign prod_ext = ACC_W'(prod);

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  acc_add_ovf #(.W(ACC_W)) u_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (acc_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    // NOTE: default assigned first so no path through this block can infer a latch.
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = CALC;
      CALC: if (last_bit) state_nx = ACC;
      ACC:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      prod  <= '0;
      mul   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          // NOTE: operand registers are left out of reset; they are always loaded on accept.
          if (in_valid) begin
            mcand <= PW'(signed'({as, a}));
            op_b  <= b;
            mode  <= acc_mode;
            prod  <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          if (op_b[0]) prod <= prod + mcand;
          mcand <= mcand <<< 1;
          op_b  <= op_b >> 1;
          cnt   <= cnt + CW'(1);
        end
        ACC: begin
          mul <= prod;
          if (mode) begin
            acc <= acc_sum;
            ovf <= ovf | add_ovf;
          end else begin
            acc <= prod_ext;
            ovf <= 1'b0;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_sxu.sv
// Scoreboard bench for seq_mult_sxu: a small instance (WA=2, WB=2, ACC_W=5) for the
// accumulate/overflow/backpressure cases, and a wide one (WB=8) for the latency-9 case.
module tb_seq_mult_sxu;

  typedef struct {
    int mul;
    int acc;
    bit ovf;
    int acc_cyc;
    bit chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q_m[$];
  exp_t q_b[$];

  // small instance
  logic              in_valid_m, in_ready_m, as_m, mode_m, out_valid_m, out_ready_m, ovf_m;
  logic [1:0]        a_m, b_m;
  logic signed [4:0] mul_m, acc_m;

  // wide instance
  logic               in_valid_b, in_ready_b, as_b, mode_b, out_valid_b, out_ready_b, ovf_b;
  logic [1:0]         a_b;
  logic [7:0]         b_b;
  logic signed [10:0] mul_b;
  logic signed [15:0] acc_b;

  seq_mult_sxu #(.WA(2), .WB(2), .ACC_W(5)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_m), .in_ready(in_ready_m),
    .as(as_m), .a(a_m), .b(b_m), .acc_mode(mode_m),
    .out_valid(out_valid_m), .out_ready(out_ready_m),
    .mul(mul_m), .acc(acc_m), .ovf(ovf_m)
  );

  seq_mult_sxu #(.WA(2), .WB(8), .ACC_W(16)) u_big (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .as(as_b), .a(a_b), .b(b_b), .acc_mode(mode_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .mul(mul_b), .acc(acc_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors sample just after the falling edge, after the stimulus has settled.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (out_valid_m && out_ready_m) begin
      if (q_m.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_main: got mul %0d acc %0d with no pending transaction",
                 mul_m, acc_m);
      end else begin
        e = q_m.pop_front();
        check("mul_main", int'(mul_m), e.mul);
        check("acc_main", int'(acc_m), e.acc);
        check("ovf_main", int'(ovf_m), int'(e.ovf));
        if (e.chk_lat) check("latency_main", cyc - e.acc_cyc, 3);
      end
    end
  end

  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (out_valid_b && out_ready_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_big: got mul %0d acc %0d with no pending transaction",
                 mul_b, acc_b);
      end else begin
        e = q_b.pop_front();
        check("mul_big", int'(mul_b), e.mul);
        check("acc_big", int'(acc_b), e.acc);
        check("ovf_big", int'(ovf_b), int'(e.ovf));
        if (e.chk_lat) check("latency_big", cyc - e.acc_cyc, 9);
      end
    end
  end

  // Drive one transaction on instance d (0 small, 1 wide); returns after the accept edge.
  task automatic send(input int d, input logic s, input logic [1:0] av, input logic [7:0] bv,
                      input logic m, input bit push, input int emul, input int eacc,
                      input bit eovf, input bit chk_lat);
    int   n;
    exp_t e;
    n = 0;
    while (!((d == 0) ? in_ready_m : in_ready_b) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check((d == 0) ? "ready_wait_main" : "ready_wait_big", int'(n < 100), 1);
    if (d == 0) begin
      as_m = s; a_m = av; b_m = bv[1:0]; mode_m = m; in_valid_m = 1'b1;
    end else begin
      as_b = s; a_b = av; b_b = bv; mode_b = m; in_valid_b = 1'b1;
    end
    if (push) begin
      e = '{emul, eacc, eovf, cyc + 1, chk_lat};
      if (d == 0) q_m.push_back(e);
      else        q_b.push_back(e);
    end
    @(negedge clk);
    in_valid_m = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? (q_m.size() != 0 || !in_ready_m) : (q_b.size() != 0 || !in_ready_b))
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    check((d == 0) ? "drain_main" : "drain_big", int'(n < 200), 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid_m = 1'b0; as_m = 1'b0; a_m = '0; b_m = '0; mode_m = 1'b0; out_ready_m = 1'b1;
    in_valid_b = 1'b0; as_b = 1'b0; a_b = '0; b_b = '0; mode_b = 1'b0; out_ready_b = 1'b1;

    repeat (2) @(negedge clk);
    check("in_ready_during_reset", int'(in_ready_m), 0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", int'(in_ready_m), 1);
    check("reset_out_valid", int'(out_valid_m), 0);
    check("reset_mul", int'(mul_m), 0);
    check("reset_acc", int'(acc_m), 0);
    check("reset_ovf", int'(ovf_m), 0);
    check("reset_in_ready_big", int'(in_ready_b), 1);

    // sign-extended a, zero b, load then accumulate
    send(0, 1'b1, 2'b00, 8'd3, 1'b0, 1, -12, -12, 1'b0, 1);
    send(0, 1'b1, 2'b00, 8'd0, 1'b0, 1,   0,   0, 1'b0, 1);
    send(0, 1'b0, 2'b11, 8'd3, 1'b0, 1,   9,   9, 1'b0, 1);
    send(0, 1'b1, 2'b00, 8'd3, 1'b1, 1, -12,  -3, 1'b0, 1);
    // 5-bit accumulator: 9 + 9 wraps to -14, ovf sticks, load clears it
    send(0, 1'b0, 2'b11, 8'd3, 1'b0, 1,   9,   9, 1'b0, 1);
    send(0, 1'b0, 2'b11, 8'd3, 1'b1, 1,   9, -14, 1'b1, 1);
    send(0, 1'b0, 2'b11, 8'd3, 1'b1, 1,   9,  -5, 1'b1, 1);
    send(0, 1'b1, 2'b00, 8'd1, 1'b0, 1,  -4,  -4, 1'b0, 1);
    wait_drain(0);

    // backpressure: -3 x 2 accumulated onto -4, held in DONE for 5 cycles
    out_ready_m = 1'b0;
    send(0, 1'b1, 2'b01, 8'd2, 1'b1, 1, -6, -10, 1'b0, 0);
    n = 0;
    while (!out_valid_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_wait", int'(n < 20), 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", int'(out_valid_m), 1);
      check("bp_in_ready", int'(in_ready_m), 0);
      check("bp_mul", int'(mul_m), -6);
      check("bp_acc", int'(acc_m), -10);
      in_valid_m = (i % 2 == 1);
      as_m = 1'b0; a_m = 2'b11; b_m = 2'b11; mode_m = 1'b0;
      @(negedge clk);
    end
    in_valid_m  = 1'b0;
    out_ready_m = 1'b1;
    wait_drain(0);

    // reset in the second CALC cycle discards the transaction
    send(0, 1'b0, 2'b11, 8'd3, 1'b1, 0, 0, 0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", int'(out_valid_m), 0);
    check("abort_in_ready", int'(in_ready_m), 0);
    check("abort_mul", int'(mul_m), 0);
    check("abort_acc", int'(acc_m), 0);
    check("abort_ovf", int'(ovf_m), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_result", int'(out_valid_m), 0);
    send(0, 1'b0, 2'b01, 8'd2, 1'b1, 1, 2, 2, 1'b0, 1);
    wait_drain(0);

    // wide instance: -1 x 255 at latency 9, abort one, then repeat
    send(1, 1'b1, 2'b11, 8'd255, 1'b0, 1, -255, -255, 1'b0, 1);
    wait_drain(1);
    send(1, 1'b0, 2'b01, 8'd7, 1'b1, 0, 0, 0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_big_out_valid", int'(out_valid_b), 0);
    check("abort_big_mul", int'(mul_b), 0);
    check("abort_big_acc", int'(acc_b), 0);
    rst = 1'b0;
    send(1, 1'b1, 2'b11, 8'd255, 1'b1, 1, -255, -255, 1'b0, 1);
    wait_drain(1);

    repeat (3) @(negedge clk);
    check("scoreboard_main_empty", q_m.size(), 0);
    check("scoreboard_big_empty", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
